halut_decoder: RTL and testbench



---
 rtl/halut_pkg.sv | 19 +
 rtl/halut_decoder_if.sv | 37 +++
 rtl/scm.sv | 52 +++++
 rtl/halut_decoder.sv | 139 +++++++++++++
 tb/tb_halut_decoder.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/halut_pkg.sv
// Shared halut definitions: default decoder geometry, accumulator width helper and common types.
package halut_pkg;

    localparam int unsigned DefK             = 16;
    localparam int unsigned DefC             = 32;
    localparam int unsigned DefDataTypeWidth = 16;

    // Summing c entries of dw bits needs clog2(c) guard bits to rule out overflow.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned c);
        return dw + $clog2(c);
    endfunction

    localparam int unsigned DefLutAddrWidth = $clog2(DefC * DefK);
    localparam int unsigned DefAccWidth     = acc_width(DefDataTypeWidth, DefC);

    typedef logic [DefLutAddrWidth-1:0]     lut_addr_t;
    typedef logic signed [DefAccWidth-1:0]  acc_t;

endpackage

// File: rtl/halut_decoder_if.sv
// Decoder bus: encoder pair stream, LUT write port, flush and the valid/ready result channel.
interface halut_decoder_if #(
    parameter int unsigned K             = halut_pkg::DefK,
    parameter int unsigned C             = halut_pkg::DefC,
    parameter int unsigned DataTypeWidth = halut_pkg::DefDataTypeWidth
);
    import halut_pkg::*;

    localparam int unsigned CAddrWidth   = $clog2(C);
    localparam int unsigned KAddrWidth   = $clog2(K);
    localparam int unsigned LutAddrWidth = $clog2(C * K);
    localparam int unsigned AccWidth     = acc_width(DataTypeWidth, C);

    logic [CAddrWidth-1:0]    c_addr_i;
    logic [KAddrWidth-1:0]    k_addr_i;
    logic                     valid_i;
    logic [LutAddrWidth-1:0]  waddr_i;
    logic [DataTypeWidth-1:0] wdata_i;
    logic                     we_i;
    logic                     clear_i;
    logic [AccWidth-1:0]      result_o;
    logic                     valid_o;
    logic                     ready_i;
    logic                     overrun_o;
    logic                     dup_err_o;

    modport master (
        output c_addr_i, k_addr_i, valid_i, waddr_i, wdata_i, we_i, clear_i, ready_i,
        input  result_o, valid_o, overrun_o, dup_err_o
    );

    modport slave (
        input  c_addr_i, k_addr_i, valid_i, waddr_i, wdata_i, we_i, clear_i, ready_i,
        output result_o, valid_o, overrun_o, dup_err_o
    );

endinterface

// File: rtl/scm.sv
// Latch-free C x K LUT memory: flat {c,k} write port, combinational (c,k) read; out-of-range reads return 0.
module scm
    import halut_pkg::*;
#(
    parameter int unsigned C             = DefC,
    parameter int unsigned K             = DefK,
    parameter int unsigned DataTypeWidth = DefDataTypeWidth,
    localparam int unsigned CAddrWidth   = $clog2(C),
    localparam int unsigned KAddrWidth   = $clog2(K),
    localparam int unsigned LutAddrWidth = $clog2(C * K)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [LutAddrWidth-1:0]  waddr_i,
    input  logic [DataTypeWidth-1:0] wdata_i,
    input  logic [CAddrWidth-1:0]    raddr_c_i,
    input  logic [KAddrWidth-1:0]    raddr_k_i,
    output logic [DataTypeWidth-1:0] rdata_o
);

    logic [DataTypeWidth-1:0] r_mem [C][K];

    function automatic logic [LutAddrWidth-1:0] entry_addr(input int c, input int k);
        return LutAddrWidth'(c * (2 ** KAddrWidth) + k);
    endfunction

    // Contents are deliberately not reset; reset only blocks writes.
    always_ff @(posedge clk_i) begin
        if (rst_ni && we_i) begin
            for (int c = 0; c < C; c++) begin
                for (int k = 0; k < K; k++) begin
                    if (waddr_i == entry_addr(c, k)) begin
                        r_mem[c][k] <= wdata_i;
                    end
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int c = 0; c < C; c++) begin
            for (int k = 0; k < K; k++) begin
                if ((int'(raddr_c_i) == c) && (int'(raddr_k_i) == k)) begin
                    rdata_o = r_mem[c][k];
                end
            end
        end
    end

endmodule

// File: rtl/halut_decoder.sv
// halut decoder: per-pair LUT lookup, C-entry row accumulation, valid/ready result register with overrun flag.
// Optional HALUT_DECODER_DUP_CHECK_EN: per-row seen mask flags repeated codebooks on dup_err_o.
module halut_decoder
    import halut_pkg::*;
#(
    parameter int unsigned K             = DefK,
    parameter int unsigned C             = DefC,
    parameter int unsigned DataTypeWidth = DefDataTypeWidth
) (
    input logic           clk_i,
    input logic           rst_i,
    halut_decoder_if.slave bus
);

    localparam int unsigned CAddrWidth = $clog2(C);
    localparam int unsigned AccWidth   = acc_width(DataTypeWidth, C);
    localparam int unsigned ExtWidth   = AccWidth - DataTypeWidth;
    localparam logic [CAddrWidth-1:0] CntLast = CAddrWidth'(C - 1);

    logic [DataTypeWidth-1:0] w_rdata;
    logic [DataTypeWidth-1:0] r_lut;
    logic                     r_lut_valid;
    logic [AccWidth-1:0]      r_acc;
    logic [CAddrWidth-1:0]    r_cnt;
    logic [AccWidth-1:0]      r_result;
    logic                     r_valid;
    logic                     r_overrun;
    logic [AccWidth-1:0]      w_lut_ext;
    logic [AccWidth-1:0]      w_sum;
    logic                     w_last;
    logic                     w_done;

    scm #(
        .C             (C),
        .K             (K),
        .DataTypeWidth (DataTypeWidth)
    ) u_lut (
        .clk_i     (clk_i),
        .rst_ni    (~rst_i),
        .we_i      (bus.we_i),
        .waddr_i   (bus.waddr_i),
        .wdata_i   (bus.wdata_i),
        .raddr_c_i (bus.c_addr_i),
        .raddr_k_i (bus.k_addr_i),
        .rdata_o   (w_rdata)
    );

    assign w_lut_ext = {{ExtWidth{r_lut[DataTypeWidth-1]}}, r_lut};
    assign w_sum     = r_acc + w_lut_ext;
    assign w_last    = (r_cnt == CntLast);
    assign w_done    = r_lut_valid && w_last;

    // Completion is decided by the entry count alone; c order from the encoders is arbitrary.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lut       <= '0;
            r_lut_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (bus.clear_i) begin
            r_lut_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_lut_valid <= bus.valid_i;
            if (bus.valid_i) begin
                r_lut <= w_rdata;
            end
            if (r_lut_valid) begin
                if (w_last) begin
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_result <= w_sum;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CAddrWidth'(1);
                end
            end
            if (w_done) begin
                r_valid <= 1'b1;
                if (r_valid && !bus.ready_i) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && bus.ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.result_o  = r_result;
    assign bus.valid_o   = r_valid;
    assign bus.overrun_o = r_overrun;

`ifdef HALUT_DECODER_DUP_CHECK_EN
    logic [C-1:0] r_seen;
    logic [C-1:0] w_c_onehot;
    logic [C-1:0] w_seen_eff;
    logic         r_dup_err;

    always_comb begin
        w_c_onehot = '0;
        for (int c = 0; c < C; c++) begin
            if (int'(bus.c_addr_i) == c) begin
                w_c_onehot[c] = 1'b1;
            end
        end
    end

    // A pair arriving on the completion edge already belongs to the next row.
    assign w_seen_eff = w_done ? '0 : r_seen;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_seen    <= '0;
            r_dup_err <= 1'b0;
        end else if (bus.clear_i) begin
            r_seen    <= '0;
            r_dup_err <= 1'b0;
        end else if (bus.valid_i) begin
            if (|(w_seen_eff & w_c_onehot)) begin
                r_dup_err <= 1'b1;
            end
            r_seen <= w_seen_eff | w_c_onehot;
        end else begin
            r_seen <= w_seen_eff;
        end
    end

    assign bus.dup_err_o = r_dup_err;
`else
    assign bus.dup_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_halut_decoder.sv
// Bench for halut_decoder: directed LUT/row scenarios and randomized rows, scored each cycle against a row-level model.
`timescale 1ns/1ps
module tb_halut_decoder;
    import halut_pkg::*;

    localparam int C  = DefC;
    localparam int K  = DefK;
    localparam int DW = DefDataTypeWidth;
    localparam int CW = $clog2(C);
    localparam int KW = $clog2(K);

`ifdef HALUT_DECODER_DUP_CHECK_EN
    localparam bit DupEn = 1'b1;
`else
    localparam bit DupEn = 1'b0;
`endif

    typedef enum int {EV_RESULT, EV_CLEAR, EV_DUP} ev_kind_t;
    typedef struct {
        int       due;
        ev_kind_t kind;
        longint   val;
    } ev_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    halut_decoder_if bus ();

    halut_decoder dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus-side model: LUT image and the row currently being assembled.
    int     lut_m [C][K];
    longint m_sum = 0;
    int     m_cnt = 0;
    bit     m_seen [C];
    ev_t    exp_q [$];

    // Output-side model, advanced by the monitor.
    bit     mon_en = 1'b0;
    bit     o_valid = 1'b0;
    bit     o_ov = 1'b0;
    bit     o_dup = 1'b0;
    bit     prev_ready = 1'b0;
    longint o_val = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic step(input bit v, input int c, input int k, input bit clr, input bit rdy,
                        input bit we, input int wc, input int wk, input int wd);
        int t;
        t = cyc;
        bus.valid_i  = v;
        bus.c_addr_i = CW'(c);
        bus.k_addr_i = KW'(k);
        bus.clear_i  = clr;
        bus.ready_i  = rdy;
        bus.we_i     = we;
        bus.waddr_i  = lut_addr_t'(wc * K + wk);
        bus.wdata_i  = DW'(wd);
        if (clr) begin
            exp_q.push_back('{t + 1, EV_CLEAR, 0});
            m_sum = 0;
            m_cnt = 0;
            foreach (m_seen[i]) m_seen[i] = 1'b0;
        end else if (v) begin
            if (DupEn && m_seen[c]) exp_q.push_back('{t + 1, EV_DUP, 0});
            m_seen[c] = 1'b1;
            m_sum += longint'(lut_m[c][k]);
            m_cnt++;
            if (m_cnt == C) begin
                exp_q.push_back('{t + 2, EV_RESULT, m_sum});
                m_sum = 0;
                m_cnt = 0;
                foreach (m_seen[i]) m_seen[i] = 1'b0;
            end
        end
        if (we) lut_m[wc][wk] = wd;
        @(posedge clk_i);
        #1;
    endtask

    task automatic pair(input int c, input int k, input bit rdy);
        step(1'b1, c, k, 1'b0, rdy, 1'b0, 0, 0, 0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, rdy, 1'b0, 0, 0, 0);
    endtask

    task automatic clear_cycle(input bit v);
        step(v, 1, 2, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic write(input int c, input int k, input int d);
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, c, k, d);
    endtask

    // mode 0: c+1, 1: constant d, 2: random signed
    task automatic load_lut(input int mode, input int d);
        for (int c = 0; c < C; c++) begin
            for (int k = 0; k < K; k++) begin
                if (mode == 0)      write(c, k, c + 1);
                else if (mode == 1) write(c, k, d);
                else                write(c, k, int'($urandom_range(0, 65535)) - 32768);
            end
        end
    endtask

    task automatic row_seq(input bit rdy);
        for (int c = 0; c < C; c++) pair(c, int'($urandom_range(0, K - 1)), rdy);
    endtask

    initial begin : monitor
        int     n;
        bit     hc, hr, hd;
        longint rv;
        ev_t    e;
        forever begin
            @(negedge clk_i);
            if (mon_en) begin
                n = cyc;
                hc = 1'b0; hr = 1'b0; hd = 1'b0; rv = 0;
                while (exp_q.size() > 0 && exp_q[0].due <= n) begin
                    e = exp_q.pop_front();
                    case (e.kind)
                        EV_CLEAR:  hc = 1'b1;
                        EV_RESULT: begin hr = 1'b1; rv = e.val; end
                        default:   hd = 1'b1;
                    endcase
                end
                if (hc) begin
                    o_valid = 1'b0;
                    o_ov    = 1'b0;
                    o_dup   = 1'b0;
                end else begin
                    if (hr) begin
                        if (o_valid && !prev_ready) o_ov = 1'b1;
                        o_valid = 1'b1;
                        o_val   = rv;
                    end else if (o_valid && prev_ready) begin
                        o_valid = 1'b0;
                    end
                    if (hd) o_dup = 1'b1;
                end
                chk("valid_o", longint'(bus.valid_o), longint'(o_valid));
                chk("overrun_o", longint'(bus.overrun_o), longint'(o_ov));
                chk("dup_err_o", longint'(bus.dup_err_o), longint'(o_dup));
                if (o_valid) chk("result_o", longint'($signed(bus.result_o)), o_val);
                prev_ready = bus.ready_i;
            end
        end
    end

    initial begin : stimulus
        int gap;
        bus.valid_i = 1'b0; bus.c_addr_i = '0; bus.k_addr_i = '0;
        bus.clear_i = 1'b0; bus.ready_i = 1'b0; bus.we_i = 1'b0;
        bus.waddr_i = '0;   bus.wdata_i = '0;
        foreach (m_seen[i]) m_seen[i] = 1'b0;

        repeat (3) @(negedge clk_i);
        chk("reset_valid_o", longint'(bus.valid_o), 0);
        chk("reset_result_o", longint'(bus.result_o), 0);
        chk("reset_overrun_o", longint'(bus.overrun_o), 0);
        chk("reset_dup_err_o", longint'(bus.dup_err_o), 0);
        @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        mon_en = 1'b1;

        // c+1 LUT, one ordered row -> 528
        load_lut(0, 0);
        row_seq(1'b1);
        idle(4, 1'b1);

        // extreme entries, no wrap
        load_lut(1, -32768);
        row_seq(1'b1);
        idle(4, 1'b1);
        load_lut(1, 32767);
        row_seq(1'b1);
        idle(4, 1'b1);

        // overrun with consumer stalled, then completion coinciding with a handshake
        load_lut(1, 1);
        row_seq(1'b0);
        row_seq(1'b0);
        idle(3, 1'b0);
        idle(2, 1'b1);
        clear_cycle(1'b0);
        row_seq(1'b0);
        row_seq(1'b0);
        idle(1, 1'b1);
        idle(3, 1'b1);

        // partial row flushed by clear with a pair in the clear cycle
        load_lut(0, 0);
        for (int i = 0; i < 10; i++) pair(i, i, 1'b1);
        clear_cycle(1'b1);
        row_seq(1'b1);
        idle(4, 1'b1);

        // write and read of the same entry in one cycle returns the old value
        write(3, 5, 7);
        for (int c = 0; c < C; c++) begin
            if (c == 3) step(1'b1, 3, 5, 1'b0, 1'b1, 1'b1, 3, 5, 100);
            else        pair(c, 5, 1'b1);
        end
        row_seq(1'b1);
        for (int c = 0; c < C; c++) pair(c, 5, 1'b1);
        idle(4, 1'b1);

        // repeated codebook within a row
        for (int i = 0; i < C; i++) pair((i == 5) ? 4 : i, i % K, 1'b1);
        idle(4, 1'b1);
        clear_cycle(1'b0);
        idle(2, 1'b1);

        // randomized rows, random consumer, gaps, concurrent writes, rare flushes
        load_lut(2, 0);
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < C; i++) begin
                gap = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 3)) : 0;
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 0, 0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, C - 1)), int'($urandom_range(0, K - 1)),
                         int'($urandom_range(0, 65535)) - 32768);
                end
                if ($urandom_range(0, 199) == 0) begin
                    clear_cycle(1'($urandom_range(0, 1)));
                end else begin
                    step(1'b1, int'($urandom_range(0, C - 1)), int'($urandom_range(0, K - 1)),
                         1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                         int'($urandom_range(0, C - 1)), int'($urandom_range(0, K - 1)),
                         int'($urandom_range(0, 65535)) - 32768);
                end
            end
        end
        idle(6, 1'b1);

        chk("events_drained", longint'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
